mux_rr_stream: RTL
==================

# mux_rr_stream

Parametrised N-channel stream multiplexer with a registered output and valid/ready handshakes on every port. It replaces the combinational 2:1 byte muxes where several producers share one consumer. Source selection is either fixed by a select input or round-robin among requesting channels. A single output register provides one-cycle latency, full throughput and clean backpressure.

## Interface
- WIDTH, 8: data width per channel, ≥1
- NCH, 4: number of input channels, ≥2
- SELW, $clog2(NCH): localparam, width of select and channel-ID fields

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  NCH*WIDTH  channel i at [i*WIDTH +: WIDTH]
- in_valid  in  NCH  per-channel word available
- in_ready  out  NCH  per-channel accept (at most one bit high)
- mode  in  1  0 = fixed select, 1 = round-robin
- sel  in  SELW  source channel in fixed mode
- out_data  out  WIDTH  registered output word
- out_valid  out  1  out_data holds a word
- out_ready  in  1  consumer accepts
- out_ch  out  SELW  source channel of the word in out_data
- xfer_cnt  out  16  count of output transfers

## Operation
- Output register states: EMPTY (out_valid=0), FULL (out_valid=1).
- load_en = !out_valid || out_ready. A drain and a load may occur in the same cycle.
- Grant g, grant_ok:
  - mode=0: g = sel. grant_ok = (sel < NCH). An out-of-range sel grants nothing.
  - mode=1: g is the first channel with in_valid set, searching ptr, ptr+1, … mod NCH. grant_ok = |in_valid.
- in_ready[g] = load_en && grant_ok && rst_n. All other in_ready bits are 0. in_ready is combinational from out_valid, out_ready, mode, sel, in_valid and ptr.
- Input transfer: in_valid[g] && in_ready[g]. On the next edge:
  - out_data <= in_data[g]
  - out_ch <= g
  - out_valid <= 1
  - ptr <= (g+1) mod NCH. ptr updates in both modes.
- Output transfer: out_valid && out_ready. If there is no simultaneous input transfer, out_valid <= 0. out_data and out_ch keep their last value.
- xfer_cnt increments on each output transfer and wraps 0xFFFF→0x0000.
- mode and sel changes take effect combinationally in the same cycle. A word already held is never altered or discarded.
- Reset (rst_n=0, asynchronous):
  - out_valid=0, out_data=0, out_ch=0, ptr=0, xfer_cnt=0.
  - in_ready is forced to 0 while rst_n is low.
  - Reset mid-transfer discards the held word.

## Timing
- Latency: 1 cycle from an input transfer to out_valid=1 with that word.
- Throughput: 1 word/cycle while out_ready=1 and a granted channel is valid.
- Backpressure: when out_valid=1 and out_ready=0, all in_ready bits are 0 and out_data/out_ch are stable.
- Round-robin fairness: with all NCH channels continuously valid, each channel is granted exactly once per NCH consecutive transfers.
- No combinational path from in_data to out_data.

## Test plan
- Reset: apply rst_n=0 mid-stream, asynchronously between edges. Required: out_valid=0, out_data=0x00, in_ready=0000 immediately; xfer_cnt=0. After release, the first transfer appears one cycle after grant.
- Fixed mode, pass-through:
  - Stimulus: mode=0, sel=2, ch2 data=0xA5 valid, ch0/1/3 valid, out_ready=1.
  - Required: in_ready=0100. Next cycle out_data=0xA5, out_ch=2, out_valid=1.
- Round-robin, full load:
  - Stimulus: mode=1, all four channels continuously valid with data 0x10+i, out_ready=1, starting from reset.
  - Required: out_ch sequence 0,1,2,3,0,1 on consecutive cycles; xfer_cnt increments every cycle.
- Round-robin, sparse and wrap:
  - Stimulus: only ch1 and ch3 valid, with ptr just past ch3.
  - Required: grant order 1,3,1,3, with no idle cycles.
- Backpressure:
  - Stimulus: hold word 0x3C with out_ready=0 for 5 cycles, then raise out_ready with ch0 valid, data 0x77.
  - Required: in_ready=0000 and out_data=0x3C during the hold. In the release cycle, in_ready[0]=1. Next cycle out_data=0x77.
- Out-of-range select and counter wrap:
  - Stimulus: NCH=3 instance, mode=0, sel=3.
  - Required: in_ready=000 and out_valid stays 0.
  - Stimulus: 65536 output transfers from reset.
  - Required: xfer_cnt=0x0000 after the last transfer.

Source files
------------

// File: rtl/mux_rr_stream.sv
// N-channel stream multiplexer with one registered output stage.
// Source is picked by a fixed select or round-robin among valid channels.
module mux_rr_stream #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NCH   = 4,
    localparam int unsigned SELW = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_ch,
    output logic [15:0]          xfer_cnt
);

    // One extra bit so ptr + offset never overflows before the modulo fold.
    localparam int unsigned CW   = SELW + 1;
    localparam int unsigned CNTW = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [SELW-1:0]   ptr;
    logic [SELW-1:0]   ptr_nxt;
    logic [SELW-1:0]   rr_grant;
    logic              rr_found;
    logic [CW-1:0]     idx;
    logic [SELW-1:0]   grant;
    logic              grant_ok;
    logic              load_en;
    logic              in_xfer;
    logic              out_xfer;
    logic [WIDTH-1:0]  ch_data [NCH];

    // Unpack the flat input bus into per-channel words.
    for (genvar i = 0; i < NCH; i++) begin : g_unpack
        assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    // Round-robin search: first valid channel starting at ptr, wrapping mod NCH.
    always_comb begin
        rr_grant = '0;
        rr_found = 1'b0;
        idx      = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            idx = CW'(ptr) + CW'(k);
            if (idx >= CW'(NCH)) begin
                idx = idx - CW'(NCH);
            end
            if (!rr_found && in_valid[idx[SELW-1:0]]) begin
                rr_found = 1'b1;
                rr_grant = idx[SELW-1:0];
            end
        end
    end

    // Grant selection, per-channel ready and transfer strobes.
    always_comb begin
        grant    = '0;
        grant_ok = 1'b0;
        in_ready = '0;
        if (mode) begin
            grant    = rr_grant;
            grant_ok = |in_valid;
        end else begin
            grant    = sel;
            grant_ok = (CW'(sel) < CW'(NCH));
        end
        load_en = (state == EMPTY) || out_ready;
        if (load_en && grant_ok && rst_n) begin
            in_ready[grant] = 1'b1;
        end
        in_xfer  = |(in_ready & in_valid);
        out_xfer = (state == FULL) && out_ready;
        ptr_nxt  = (grant == SELW'(NCH - 1)) ? '0 : grant + SELW'(1);
    end

    // Output-register occupancy: next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (in_xfer) state_nxt = FULL;
            FULL:  if (out_xfer && !in_xfer) state_nxt = EMPTY;
        endcase
    end

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    assign out_valid = (state == FULL);

    // Capture the granted word and advance the round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_ch   <= '0;
            ptr      <= '0;
        end else if (in_xfer) begin
            out_data <= ch_data[grant];
            out_ch   <= grant;
            ptr      <= ptr_nxt;
        end
    end

    // Count output transfers, wrapping naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
        end else if (out_xfer) begin
            xfer_cnt <= xfer_cnt + CNTW'(1);
        end
    end

endmodule
